rx_mem_arbiter: RTL and testbench

Round-robin scheduler that shares the single write port of the rx audio sample memory among NCH receiver channels, all in the adc_clk domain. It latches each channel's sample-available strobe and fetches that channel's I then Q word through the shared get handshake. It writes both words at a computed double-buffered address and signals the buffer-complete event toward the cpu-side service-request logic. It sits between the per-channel rx DDC instances and the shared audio sample RAM.

---
 rtl/rx_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_rx_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_mem_arbiter.sv
// rx_mem_arbiter
//   Round-robin scheduler sharing the single write port of the rx audio
//   sample memory among NCH receiver channels (all in the adc_clk domain).
//   Each channel's sample-available strobe is latched as "pending"; the FSM
//   grants one pending channel at a time, fetches its I then Q word over the
//   shared get strobes and writes both words into a double-buffered memory.
//
// Ports
//   adc_clk, reset        : clock, synchronous active-high reset
//   chan_en[NCH]          : channel enables, taken into account only in IDLE
//   nrx_samps[16]         : samples per channel per buffer half (0 acts as 1)
//   rx_avail[NCH]         : one-cycle "new sample" pulse per channel
//   rx_din[16]            : selected channel data, valid the cycle after a get
//   chan_sel[3]           : channel being serviced
//   get_i, get_q          : one-cycle read strobes to the selected channel
//   wr_en, wr_addr, wr_data : memory write port
//   buf_done              : one-cycle pulse when a buffer half is complete
//   buf_sel               : buffer half currently being filled
//   overrun               : sticky, a sample was dropped
//
// Handshake: get_i/get_q are fire-and-forget strobes; the channel presents
// the requested word on rx_din exactly one cycle later with no back-pressure.
// wr_en has no ready: the memory accepts every write in the cycle it is high.
module rx_mem_arbiter #(
    parameter int NCH = 4,
    parameter int AW  = 13
) (
    input  logic           adc_clk,
    input  logic           reset,
    input  logic [NCH-1:0] chan_en,
    input  logic [15:0]    nrx_samps,
    input  logic [NCH-1:0] rx_avail,
    input  logic [15:0]    rx_din,
    output logic [2:0]     chan_sel,
    output logic           get_i,
    output logic           get_q,
    output logic           wr_en,
    output logic [AW-1:0]  wr_addr,
    output logic [15:0]    wr_data,
    output logic           buf_done,
    output logic           buf_sel,
    output logic           overrun
);

    localparam int LW = AW - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GET_I = 2'd1,
        S_GET_Q = 2'd2,
        S_WR_Q  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] served_q, served_d;
    logic [NCH-1:0] en_q, en_d;
    logic [15:0]    samp_idx_q, samp_idx_d;
    logic [2:0]     last_grant_q, last_grant_d;
    logic [2:0]     chan_sel_q, chan_sel_d;
    logic           buf_sel_q, buf_sel_d;
    logic           buf_done_q, buf_done_d;
    logic           overrun_q, overrun_d;

    logic [NCH-1:0] en_eff;
    logic [NCH-1:0] sel_oh;
    logic [NCH-1:0] pend_clr;
    logic [NCH-1:0] pend_vis;
    logic [NCH-1:0] pend_shift;
    logic [NCH-1:0] served_now;
    logic [15:0]    samp_last;
    logic [LW-1:0]  addr_low;
    logic           q_word;
    logic           found;
    logic [2:0]     pick;
    int unsigned    cand;

    always_comb begin
        state_d      = state_q;
        served_d     = served_q;
        samp_idx_d   = samp_idx_q;
        last_grant_d = last_grant_q;
        chan_sel_d   = chan_sel_q;
        buf_sel_d    = buf_sel_q;
        buf_done_d   = 1'b0;
        overrun_d    = overrun_q;
        get_i        = 1'b0;
        get_q        = 1'b0;
        wr_en        = 1'b0;
        q_word       = 1'b0;
        pend_clr     = '0;

        // The live enable is only honoured while idle; during a service the
        // enable captured at grant time stays in force.
        en_eff = (state_q == S_IDLE) ? chan_en : en_q;
        en_d   = en_eff;

        sel_oh     = {{(NCH-1){1'b0}}, 1'b1} << chan_sel_q;
        served_now = served_q | sel_oh;
        samp_last  = (nrx_samps == 16'd0) ? 16'd0 : nrx_samps - 16'd1;

        // Round-robin: first pending channel at or after last_grant+1.
        pend_vis   = pending_q & en_eff;
        found      = 1'b0;
        pick       = '0;
        cand       = 0;
        pend_shift = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand       = (32'(last_grant_q) + 32'(k)) % 32'(NCH);
            pend_shift = pend_vis >> cand;
            if (!found && pend_shift[0]) begin
                found = 1'b1;
                pick  = 3'(cand);
            end
        end

        case (state_q)
            S_IDLE: begin
                // Disabled channels drop out of the round so it can complete.
                served_d = served_q & chan_en;
                if (found) begin
                    chan_sel_d = pick;
                    state_d    = S_GET_I;
                end
            end
            S_GET_I: begin
                get_i   = 1'b1;
                state_d = S_GET_Q;
            end
            S_GET_Q: begin
                // I word arrives now (requested last cycle); request Q.
                get_q    = 1'b1;
                wr_en    = 1'b1;
                pend_clr = sel_oh;
                state_d  = S_WR_Q;
            end
            S_WR_Q: begin
                wr_en        = 1'b1;
                q_word       = 1'b1;
                last_grant_d = chan_sel_q;
                state_d      = S_IDLE;
                if (served_now == en_q && en_q != '0) begin
                    served_d = '0;
                    if (samp_idx_q >= samp_last) begin
                        samp_idx_d = '0;
                        buf_sel_d  = ~buf_sel_q;
                        buf_done_d = 1'b1;
                    end else begin
                        samp_idx_d = samp_idx_q + 16'd1;
                    end
                end else begin
                    served_d = served_now;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new strobe on a channel being fetched this cycle is kept (set
        // wins) and is not a drop; a strobe on any other pending channel is.
        pending_d = (pending_q & en_eff & ~pend_clr) | (rx_avail & en_eff);
        if (|(rx_avail & en_eff & pending_q & ~pend_clr)) begin
            overrun_d = 1'b1;
        end

        addr_low = LW'((32'(samp_idx_q) * 32'(NCH) + 32'(chan_sel_q)) * 32'd2
                       + 32'(q_word));
        wr_addr  = wr_en ? {buf_sel_q, addr_low} : '0;
        wr_data  = wr_en ? rx_din : 16'd0;
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            served_q     <= '0;
            en_q         <= '0;
            samp_idx_q   <= '0;
            last_grant_q <= 3'(NCH - 1);
            chan_sel_q   <= '0;
            buf_sel_q    <= 1'b0;
            buf_done_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            served_q     <= served_d;
            en_q         <= en_d;
            samp_idx_q   <= samp_idx_d;
            last_grant_q <= last_grant_d;
            chan_sel_q   <= chan_sel_d;
            buf_sel_q    <= buf_sel_d;
            buf_done_q   <= buf_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign chan_sel = chan_sel_q;
    assign buf_sel  = buf_sel_q;
    assign buf_done = buf_done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_rx_mem_arbiter.sv
module tb_rx_mem_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 13;
    localparam int W   = AW + 16;

    // ---------------- clock / reset / DUT ----------------
    logic           adc_clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] chan_en = '0;
    logic [15:0]    nrx_samps = 16'd2;
    logic [NCH-1:0] rx_avail = '0;
    logic [15:0]    rx_din = 16'd0;
    logic [2:0]     chan_sel;
    logic           get_i, get_q, wr_en, buf_done, buf_sel, overrun;
    logic [AW-1:0]  wr_addr;
    logic [15:0]    wr_data;

    always #5 adc_clk = ~adc_clk;

    rx_mem_arbiter #(.NCH(NCH), .AW(AW)) dut (
        .adc_clk(adc_clk), .reset(reset), .chan_en(chan_en),
        .nrx_samps(nrx_samps), .rx_avail(rx_avail), .rx_din(rx_din),
        .chan_sel(chan_sel), .get_i(get_i), .get_q(get_q), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .buf_done(buf_done),
        .buf_sel(buf_sel), .overrun(overrun)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge adc_clk) cyc <= cyc + 1;

    // Channel model: every get returns the next word of a running sequence.
    logic [15:0] din_base = 16'd0;
    int          get_cnt = 0;
    always @(posedge adc_clk) begin
        if (get_i || get_q) begin
            rx_din  <= din_base + 16'(get_cnt);
            get_cnt <= get_cnt + 1;
        end
    end

    // Monitor, sampled on the falling edge.
    logic [W-1:0] act_q[$];
    int           act_cyc[$];
    int           grant_q[$];
    int           grant_cyc[$];
    int           done_cnt = 0;
    always @(negedge adc_clk) begin
        if (wr_en) begin
            act_q.push_back({wr_addr, wr_data});
            act_cyc.push_back(cyc);
        end
        if (get_i) begin
            grant_q.push_back(int'(chan_sel));
            grant_cyc.push_back(cyc);
        end
        if (buf_done) done_cnt++;
    end

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    int exp_done = 0;
    int m_last, m_samp, m_bsel, m_en, m_served, m_nrx, m_din;

    task automatic model_reset();
        m_last = NCH - 1; m_samp = 0; m_bsel = 0; m_served = 0;
    endtask

    task automatic model_service(int ch);
        int low, addr;
        low  = ((m_samp * NCH + ch) * 2) % (1 << (AW - 1));
        addr = (m_bsel << (AW - 1)) + low;
        exp_q.push_back({AW'(addr), 16'(m_din)});
        exp_q.push_back({AW'(addr + 1), 16'(m_din + 1)});
        m_din += 2;
        m_served |= (1 << ch);
        m_last = ch;
        if (m_served == m_en && m_en != 0) begin
            m_served = 0;
            m_samp++;
            if (m_samp >= ((m_nrx == 0) ? 1 : m_nrx)) begin
                m_samp = 0;
                m_bsel ^= 1;
                exp_done++;
            end
        end
    endtask

    // All channels in 'set' became pending together while idle.
    task automatic model_burst(int set);
        int s;
        s = set & m_en;
        while (s != 0) begin
            for (int off = 1; off <= NCH; off++) begin
                int ch;
                ch = (m_last + off) % NCH;
                if (s[ch]) begin
                    model_service(ch);
                    s[ch] = 1'b0;
                    break;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic pulse(logic [NCH-1:0] m);
        rx_avail = m;
        tick();
        rx_avail = '0;
    endtask

    task automatic clear_logs();
        act_q.delete(); act_cyc.delete(); grant_q.delete(); grant_cyc.delete();
        exp_q.delete(); exp_done = 0; done_cnt = 0;
    endtask

    task automatic sync_din(int start);
        din_base = 16'(start) - 16'(get_cnt);
        m_din = start;
    endtask

    task automatic do_reset(logic [NCH-1:0] en, logic [15:0] nrx);
        chan_en = en; nrx_samps = nrx; rx_avail = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        m_en = int'(en); m_nrx = int'(nrx);
        clear_logs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        chan_en = '1; reset = 1'b1; rx_avail = '0;
        repeat (3) tick();
        checks++; if (chan_sel !== 3'd0) begin failures++; $display("FAIL reset_chan_sel got=%0d want=0", chan_sel); end
        checks++; if (get_i !== 1'b0) begin failures++; $display("FAIL reset_get_i got=%b want=0", get_i); end
        checks++; if (get_q !== 1'b0) begin failures++; $display("FAIL reset_get_q got=%b want=0", get_q); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
        checks++; if (wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr got=%h want=0", wr_addr); end
        checks++; if (wr_data !== 16'd0) begin failures++; $display("FAIL reset_wr_data got=%h want=0", wr_data); end
        checks++; if (buf_done !== 1'b0) begin failures++; $display("FAIL reset_buf_done got=%b want=0", buf_done); end
        checks++; if (buf_sel !== 1'b0) begin failures++; $display("FAIL reset_buf_sel got=%b want=0", buf_sel); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_basic();
        int n;
        do_reset(4'hF, 16'd2);
        sync_din(16'h100);
        n = cyc;
        pulse(4'hF);
        model_burst(15);
        repeat (20) tick();
        pulse(4'hF);
        model_burst(15);
        repeat (20) tick();
        checks++; if (act_q.size() != 16) begin failures++; $display("FAIL basic_count got=%0d want=16", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < 16; i++) begin
            checks++;
            if (act_q[i] !== {AW'(i), 16'(16'h100 + i)}) begin
                failures++; $display("FAIL basic_write[%0d] got=%h want=%h", i, act_q[i], {AW'(i), 16'(16'h100 + i)});
            end
            checks++;
            if (act_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_model[%0d] got=%h want=%h", i, act_q[i], exp_q[i]); end
        end
        for (int i = 0; i + 1 < act_cyc.size(); i += 2) begin
            checks++;
            if (act_cyc[i+1] != act_cyc[i] + 1) begin failures++; $display("FAIL basic_pair[%0d] got=%0d want=%0d", i, act_cyc[i+1], act_cyc[i] + 1); end
        end
        checks++; if (grant_cyc.size() == 0 || grant_cyc[0] != n + 2) begin failures++; $display("FAIL basic_get_i_latency got=%0d want=%0d", (grant_cyc.size() > 0) ? grant_cyc[0] : -1, n + 2); end
        checks++; if (act_cyc.size() == 0 || act_cyc[0] != n + 3) begin failures++; $display("FAIL basic_wr_latency got=%0d want=%0d", (act_cyc.size() > 0) ? act_cyc[0] : -1, n + 3); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_buf_done got=%0d want=1", done_cnt); end
        checks++; if (buf_sel !== 1'b1) begin failures++; $display("FAIL basic_buf_sel got=%b want=1", buf_sel); end
    endtask

    task automatic test_chan_mask();
        int want[4] = '{0, 1, 4, 5};
        do_reset(4'b0101, 16'd2);
        sync_din($urandom_range(0, 16'hFFFF));
        pulse(4'hF);
        model_burst(15);
        repeat (20) tick();
        pulse(4'hF);
        model_burst(15);
        repeat (20) tick();
        checks++; if (act_q.size() != exp_q.size()) begin failures++; $display("FAIL mask_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin failures++; $display("FAIL mask_write[%0d] got=%h want=%h", i, act_q[i], exp_q[i]); end
        end
        for (int i = 0; i < 4 && i < act_q.size(); i++) begin
            checks++;
            if (int'(act_q[i][W-1:16]) != want[i]) begin failures++; $display("FAIL mask_addr[%0d] got=%0d want=%0d", i, act_q[i][W-1:16], want[i]); end
        end
        // second sample index lands at samp_idx=1: addresses 8,9,12,13
        checks++; if (act_q.size() < 5 || int'(act_q[4][W-1:16]) != 8) begin failures++; $display("FAIL mask_samp_idx got=%0d want=8", (act_q.size() >= 5) ? int'(act_q[4][W-1:16]) : -1); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL mask_buf_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_random_rounds();
        logic [NCH-1:0] en;
        logic [15:0]    nrx;
        logic [NCH-1:0] set;
        do_reset(4'hF, 16'd2);
        sync_din($urandom_range(0, 16'hFFFF));
        for (int it = 0; it < 12; it++) begin
            en  = NCH'($urandom_range(1, 15));
            nrx = 16'($urandom_range(0, 3));
            chan_en = en; nrx_samps = nrx;
            m_en = int'(en); m_nrx = int'(nrx); m_served &= m_en;
            tick();
            set = NCH'($urandom_range(1, 15));
            pulse(set);
            model_burst(int'(set));
            repeat (4 * NCH + 8) tick();
        end
        checks++; if (act_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_write[%0d] got=%h want=%h", i, act_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt != exp_done) begin failures++; $display("FAIL rand_buf_done got=%0d want=%0d", done_cnt, exp_done); end
        checks++; if (buf_sel !== m_bsel[0]) begin failures++; $display("FAIL rand_buf_sel got=%b want=%b", buf_sel, m_bsel[0]); end
    endtask

    task automatic test_fairness();
        do_reset(4'b1010, 16'd100);
        for (int t = 0; t < 60; t++) begin
            rx_avail = (t % 3 == 0) ? 4'b1010 : 4'b0000;
            tick();
        end
        rx_avail = '0;
        repeat (20) tick();
        checks++; if (grant_q.size() < 8) begin failures++; $display("FAIL fair_count got=%0d want>=8", grant_q.size()); end
        for (int i = 0; i < grant_q.size(); i++) begin
            checks++;
            if (grant_q[i] != ((i % 2 == 0) ? 1 : 3)) begin
                failures++; $display("FAIL fair_grant[%0d] got=%0d want=%0d", i, grant_q[i], (i % 2 == 0) ? 1 : 3);
            end
        end
    endtask

    task automatic test_overrun();
        int ch0_words;
        do_reset(4'hF, 16'd4);
        sync_din($urandom_range(0, 16'hFFFF));
        pulse(4'b0010);
        tick();
        pulse(4'b0001);
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b want=0", overrun); end
        pulse(4'b0001);
        model_burst(2);
        model_burst(1);
        repeat (20) tick();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
        checks++; if (act_q.size() != exp_q.size()) begin failures++; $display("FAIL ovr_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovr_write[%0d] got=%h want=%h", i, act_q[i], exp_q[i]); end
        end
        ch0_words = 0;
        foreach (act_q[i]) if (((int'(act_q[i][W-2:16]) / 2) % NCH) == 0) ch0_words++;
        checks++; if (ch0_words != 2) begin failures++; $display("FAIL ovr_ch0_words got=%0d want=2", ch0_words); end
    endtask

    task automatic test_nrx_zero();
        do_reset(4'b0011, 16'd0);
        sync_din($urandom_range(0, 16'hFFFF));
        for (int r = 0; r < 3; r++) begin
            pulse(4'b0011);
            model_burst(3);
            repeat (14) tick();
            checks++; if (done_cnt != r + 1) begin failures++; $display("FAIL nrx0_done[%0d] got=%0d want=%0d", r, done_cnt, r + 1); end
            checks++; if (buf_sel !== ((r % 2 == 0) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL nrx0_buf_sel[%0d] got=%b want=%b", r, buf_sel, (r % 2 == 0)); end
        end
        checks++; if (act_q.size() != exp_q.size()) begin failures++; $display("FAIL nrx0_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin failures++; $display("FAIL nrx0_write[%0d] got=%h want=%h", i, act_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int n, late;
        do_reset(4'hF, 16'd2);
        n = cyc;
        pulse(4'b0100);
        tick();
        checks++; if (get_i !== 1'b1) begin failures++; $display("FAIL rmid_get_i got=%b want=1", get_i); end
        tick();
        checks++; if (wr_en !== 1'b1 || get_q !== 1'b1) begin failures++; $display("FAIL rmid_get_q got=%b%b want=11", wr_en, get_q); end
        reset = 1'b1;
        tick();
        checks++;
        if ({chan_sel, get_i, get_q, wr_en, wr_addr, wr_data, buf_done, buf_sel, overrun} !== '0) begin
            failures++; $display("FAIL rmid_outputs got sel=%0d gi=%b gq=%b we=%b a=%h d=%h bd=%b bs=%b ov=%b want all 0",
                chan_sel, get_i, get_q, wr_en, wr_addr, wr_data, buf_done, buf_sel, overrun);
        end
        reset = 1'b0;
        repeat (10) tick();
        late = 0;
        foreach (act_cyc[i]) if (act_cyc[i] > n + 3) late++;
        checks++; if (late != 0) begin failures++; $display("FAIL rmid_no_write got=%0d want=0", late); end
        model_reset();
        clear_logs();
        sync_din($urandom_range(0, 16'hFFFF));
        pulse(4'b0001);
        model_burst(1);
        repeat (10) tick();
        checks++; if (act_q.size() != 2) begin failures++; $display("FAIL rmid_count got=%0d want=2", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_write[%0d] got=%h want=%h", i, act_q[i], exp_q[i]); end
        end
        checks++; if (act_q.size() == 0 || act_q[0][W-1:16] !== '0) begin failures++; $display("FAIL rmid_addr0 got=%h want=0", (act_q.size() > 0) ? act_q[0][W-1:16] : '1); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_chan_mask();
        test_random_rounds();
        test_fairness();
        test_overrun();
        test_nrx_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
